router_fsm_nch: RTL

Parametrised successor of the router packet-control FSM. It steers one input packet stream to one of NUM_CH output FIFOs using the header address. It generates the load, parity and full-handling strobes for the register and FIFO blocks, and integrates the per-channel read-timeout soft-reset generators. Invalid addresses, which the previous FSM could not handle, are dropped in a dedicated state. It sits between the input register block and the NUM_CH FIFO/sync blocks of the router top.

---
 rtl/router_fsm_nch.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/router_fsm_nch.sv
// -----------------------------------------------------------------------------
// router_fsm_nch
//
// Packet-control FSM for the router. It steers one input packet stream to one
// of NUM_CH output FIFOs selected by the header address. It produces the
// load/parity/full-handling strobes for the register and FIFO blocks, and holds
// the per-channel read-timeout soft-reset generators. Headers that carry an
// address with no matching channel are discarded in a dedicated DROP state.
//
// Parameters
//   NUM_CH   number of output channels (2..8)
//   ADDR_W   header address field width, 2**ADDR_W >= NUM_CH
//   TIMEOUT  cycles a channel may hold vld_out without read_enb before its
//            soft reset fires
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   pkt_valid             input packet valid (header and payload)
//   low_packet_valid      parity byte still pending after full recovery
//   parity_done           parity byte captured by the register block
//   data_in               address field of the header byte
//   fifo_full/fifo_empty  per-channel FIFO status
//   vld_out/read_enb      per-channel output valid / read enable
//   write_enb             one-hot FIFO write select for the latched channel
//   soft_reset            per-channel timeout soft reset, one-cycle pulse
//   detect_add, lfd_state, ld_state, laf_state, full_state, drop_state
//                         state decodes
//   write_enb_reg         register/FIFO write strobe
//   rst_int_reg           clear the internal parity register
//   busy                  stall the upstream source
//   drop_count            (only with ROUTER_FSM_DROP_CNT_EN) saturating count
//                         of packets discarded for an invalid address
//
// Optional build macro: ROUTER_FSM_DROP_CNT_EN
// -----------------------------------------------------------------------------
module router_fsm_nch #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic              low_packet_valid,
    input  logic              parity_done,
    input  logic [ADDR_W-1:0] data_in,
    input  logic [NUM_CH-1:0] fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] vld_out,
    input  logic [NUM_CH-1:0] read_enb,
    output logic [NUM_CH-1:0] write_enb,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy,
    output logic              drop_state
`ifdef ROUTER_FSM_DROP_CNT_EN
    ,
    output logic [7:0]        drop_count
`endif
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        ST_DA   = 4'd0,
        ST_LFD  = 4'd1,
        ST_LD   = 4'd2,
        ST_FFS  = 4'd3,
        ST_LAF  = 4'd4,
        ST_LP   = 4'd5,
        ST_CPE  = 4'd6,
        ST_WTE  = 4'd7,
        ST_DROP = 4'd8
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_sel;
    logic                w_addr_ok;
    logic                w_full;
    logic                w_empty;
    logic                w_soft_sel;
    logic [NUM_CH-1:0]   w_soft_reset;

    // In DECODE_ADDRESS the header is on data_in right now; elsewhere the
    // latched address selects the channel.
    assign w_sel     = (r_state == ST_DA) ? data_in : r_addr;
    assign w_addr_ok = (int'(data_in) < NUM_CH);

    // Channel muxes written as loops so an out-of-range address reads as 0
    // instead of indexing past the vectors.
    always_comb begin
        w_full     = 1'b0;
        w_empty    = 1'b0;
        w_soft_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_sel == ADDR_W'(i)) begin
                w_full  = fifo_full[i];
                w_empty = fifo_empty[i];
            end
            if (r_addr == ADDR_W'(i)) begin
                w_soft_sel = w_soft_reset[i];
            end
        end
    end

    // State and address registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_DA;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DA && pkt_valid) begin
                r_addr <= data_in;
            end
        end
    end

    // Next state and Moore decodes
    always_comb begin
        w_next        = r_state;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        drop_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b0;

        case (r_state)
            ST_DA: begin
                detect_add = 1'b1;
                if (pkt_valid && !w_addr_ok) begin
                    w_next = ST_DROP;
                end else if (pkt_valid && w_empty) begin
                    w_next = ST_LFD;
                end else if (pkt_valid) begin
                    w_next = ST_WTE;
                end
            end
            ST_LFD: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
                w_next    = ST_LD;
            end
            ST_LD: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                if (w_full) begin
                    w_next = ST_FFS;
                end else if (!pkt_valid) begin
                    w_next = ST_LP;
                end
            end
            ST_FFS: begin
                full_state = 1'b1;
                busy       = 1'b1;
                if (!w_full) begin
                    w_next = ST_LAF;
                end
            end
            ST_LAF: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
                if (parity_done) begin
                    w_next = ST_DA;
                end else if (low_packet_valid) begin
                    w_next = ST_LP;
                end else begin
                    w_next = ST_LD;
                end
            end
            ST_LP: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
                w_next        = ST_CPE;
            end
            ST_CPE: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
                w_next      = w_full ? ST_FFS : ST_DA;
            end
            ST_WTE: begin
                busy = 1'b1;
                if (w_empty) begin
                    w_next = ST_LFD;
                end
            end
            ST_DROP: begin
                drop_state = 1'b1;
                if (!pkt_valid) begin
                    w_next = ST_DA;
                end
            end
            default: begin
                w_next = ST_DA;
            end
        endcase

        // A timeout on the channel being served abandons the packet.
        if (r_state != ST_DA && w_soft_sel) begin
            w_next = ST_DA;
        end
    end

    // Per-channel write select and read-timeout generators
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            logic [CNT_W-1:0] r_cnt;
            logic             r_pulse;

            assign write_enb[gi] = (write_enb_reg | lfd_state) & (r_addr == ADDR_W'(gi));

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_cnt   <= '0;
                    r_pulse <= 1'b0;
                end else if (read_enb[gi] || !vld_out[gi] || r_pulse) begin
                    r_cnt   <= '0;
                    r_pulse <= 1'b0;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    r_cnt   <= '0;
                    r_pulse <= 1'b1;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_pulse <= 1'b0;
                end
            end

            assign w_soft_reset[gi] = r_pulse;
        end
    endgenerate

    assign soft_reset = w_soft_reset;

`ifdef ROUTER_FSM_DROP_CNT_EN
    logic [7:0] r_drop_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (r_state == ST_DA && w_next == ST_DROP && r_drop_count != 8'hFF) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule
